// File: rtl/div_issue_ctrl_if.sv
// div_issue_ctrl_if: request, divider and writeback handshakes of the divider front end
interface div_issue_ctrl_if #(parameter int TAG_W = 5);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             div_valid;
  logic             div_ready;
  logic             div_signed;
  logic [31:0]      div_z;
  logic [31:0]      div_d;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_q;
  logic [31:0]      res_s;
  logic             wb_valid;
  logic             wb_ready;
  logic [31:0]      wb_data;
  logic [TAG_W-1:0] wb_tag;
  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, div_ready, res_valid, res_q, res_s, wb_ready,
    input  req_ready, div_valid, div_signed, div_z, div_d, res_ready, wb_valid, wb_data, wb_tag
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, div_ready, res_valid, res_q, res_s, wb_ready,
    output req_ready, div_valid, div_signed, div_z, div_d, res_ready, wb_valid, wb_data, wb_tag
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: execute-stage front end that issues one divide op, returns its result and handles flush
module div_issue_ctrl #(
  parameter int TAG_W     = 5,
  parameter bit FAST_PATH = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  output logic busy,
  div_issue_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;
  state_t           state, state_nx;
  logic [1:0]       op;
  logic [31:0]      a, b, data, fast_res;
  logic [TAG_W-1:0] tag;
  logic             accept, b_zero, ovf, fast;
  assign accept   = state == IDLE && bus.req_valid && !flush;
  assign b_zero   = bus.req_b == '0;
  assign ovf      = !bus.req_op[1] && bus.req_a == 32'h8000_0000 && bus.req_b == 32'hFFFF_FFFF;
  assign fast     = FAST_PATH && (b_zero || ovf);
  assign fast_res = b_zero ? (bus.req_op[0] ? bus.req_a : 32'hFFFF_FFFF)
                           : (bus.req_op[0] ? 32'h0 : 32'h8000_0000);
  assign bus.div_signed = ~op[1];
  assign bus.div_z      = a;
  assign bus.div_d      = b;
  assign bus.wb_data    = data;
  assign bus.wb_tag     = tag;
  // state register; reset abandons any op because the divider shares rst_n
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // next state and handshake strobes decoded from state, gated by flush
  always_comb begin
    state_nx      = state;
    bus.req_ready = state == IDLE;
    busy          = state != IDLE;
    bus.div_valid = state == ISSUE && !flush;
    bus.res_ready = state == WAIT || state == DRAIN;
    bus.wb_valid  = state == DONE && !flush;
    case (state)
      IDLE:    state_nx = accept ? (fast ? DONE : ISSUE) : IDLE;
      ISSUE:   state_nx = flush ? IDLE : (bus.div_ready ? WAIT : ISSUE);
      WAIT:    state_nx = bus.res_valid ? (flush ? IDLE : DONE) : (flush ? DRAIN : WAIT);
      DRAIN:   state_nx = bus.res_valid ? IDLE : DRAIN;
      DONE:    state_nx = (flush || bus.wb_ready) ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // operand latch on accept; result captured from the fast path or the divider
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op   <= '0;
      a    <= '0;
      b    <= '0;
      tag  <= '0;
      data <= '0;
    end else begin
      if (accept) begin
        op  <= bus.req_op;
        a   <= bus.req_a;
        b   <= bus.req_b;
        tag <= bus.req_tag;
        if (fast) data <= fast_res;
      end
      if (state == WAIT && bus.res_valid && !flush) data <= op[0] ? bus.res_s : bus.res_q;
    end
  end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: directed-vector bench for the divider issue controller
module tb_div_issue_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic busy;
  int n_vec = 0;
  int n_err = 0;
  div_issue_ctrl_if #(.TAG_W(5)) bus();
  div_issue_ctrl #(.TAG_W(5), .FAST_PATH(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .busy(busy), .bus(bus.slave)
  );
  always #5 clk = ~clk;

  logic [1:0]  dv_op  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3};
  logic [31:0] dv_a   [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] dv_b   [6] = '{32'h2, 32'h2, 32'h10, 32'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] dv_q   [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h0FFF_FFFF, 32'h0FFF_FFFF, 32'h0, 32'h0};
  logic [31:0] dv_s   [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF, 32'hF, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] dv_exp [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0FFF_FFFF, 32'hF, 32'h0, 32'h8000_0000};
  logic [4:0]  dv_tag [6] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};

  logic [1:0]  fp_op  [6] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [31:0] fp_a   [6] = '{32'h64, 32'h5, 32'h8000_0000, 32'h8000_0000, 32'h9, 32'h7};
  logic [31:0] fp_b   [6] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
  logic [31:0] fp_exp [6] = '{32'hFFFF_FFFF, 32'h5, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'h7};
  logic [4:0]  fp_tag [6] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'd0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_tag   = '0;
    bus.div_ready = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_q     = '0;
    bus.res_s     = '0;
    bus.wb_ready  = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic send_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tg);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tg;
    tick();
    bus.req_valid = 1'b0;
  endtask

  // runs one op acting as the divider; returns observations, compares nothing
  task automatic do_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tg,
                        input logic [31:0] q, input logic [31:0] s,
                        output logic [31:0] data, output logic [4:0] tag_o, output int wb_cyc,
                        output bit div_seen, output logic [31:0] z, output logic [31:0] d, output logic sg);
    int cyc;
    div_seen = 1'b0;
    z = '0;
    d = '0;
    sg = 1'b0;
    send_req(op, a, b, tg);
    cyc = 1;
    while (!bus.wb_valid && cyc < 40) begin
      if (bus.div_valid) begin
        div_seen = 1'b1;
        bus.div_ready = 1'b1;
        tick();
        bus.div_ready = 1'b0;
        z  = bus.div_z;
        d  = bus.div_d;
        sg = bus.div_signed;
        tick();
        tick();
        cyc += 3;
        bus.res_valid = 1'b1;
        bus.res_q = q;
        bus.res_s = s;
        tick();
        bus.res_valid = 1'b0;
        cyc++;
      end else begin
        tick();
        cyc++;
      end
    end
    wb_cyc = cyc;
    data   = bus.wb_data;
    tag_o  = bus.wb_tag;
    if (bus.wb_valid) begin
      bus.wb_ready = 1'b1;
      tick();
      bus.wb_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset req_ready got %b exp 1", bus.req_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy got %b exp 0", busy); end
    n_vec++; if ({bus.div_valid, bus.res_ready, bus.wb_valid} !== 3'b000) begin n_err++; $display("FAIL reset strobes got %b exp 000", {bus.div_valid, bus.res_ready, bus.wb_valid}); end
    n_vec++; if (bus.wb_data !== 32'h0) begin n_err++; $display("FAIL reset wb_data got %h exp 0", bus.wb_data); end
    n_vec++; if (bus.wb_tag !== 5'd0) begin n_err++; $display("FAIL reset wb_tag got %h exp 0", bus.wb_tag); end
    n_vec++; if ({bus.div_z, bus.div_d} !== 64'h0) begin n_err++; $display("FAIL reset operands got %h %h exp 0 0", bus.div_z, bus.div_d); end
    n_vec++; if (bus.div_signed !== 1'b1) begin n_err++; $display("FAIL reset div_signed got %b exp 1", bus.div_signed); end
  endtask

  task automatic test_divide;
    logic [31:0] data, z, d;
    logic [4:0] tg;
    int wc;
    bit seen;
    logic sg;
    for (int i = 0; i < 6; i++) begin
      do_div(dv_op[i], dv_a[i], dv_b[i], dv_tag[i], dv_q[i], dv_s[i], data, tg, wc, seen, z, d, sg);
      n_vec++; if (data !== dv_exp[i]) begin n_err++; $display("FAIL div[%0d] wb_data got %h exp %h", i, data, dv_exp[i]); end
      n_vec++; if (tg !== dv_tag[i]) begin n_err++; $display("FAIL div[%0d] wb_tag got %0d exp %0d", i, tg, dv_tag[i]); end
      n_vec++; if (wc !== 5) begin n_err++; $display("FAIL div[%0d] wb cycle got %0d exp 5", i, wc); end
      n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL div[%0d] div_valid seen got %b exp 1", i, seen); end
      n_vec++; if (z !== dv_a[i] || d !== dv_b[i]) begin n_err++; $display("FAIL div[%0d] div_z/div_d got %h/%h exp %h/%h", i, z, d, dv_a[i], dv_b[i]); end
      n_vec++; if (sg !== ~dv_op[i][1]) begin n_err++; $display("FAIL div[%0d] div_signed got %b exp %b", i, sg, ~dv_op[i][1]); end
      n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL div[%0d] req_ready after wb got %b exp 1", i, bus.req_ready); end
    end
  endtask

  task automatic test_fast_path;
    logic [31:0] data, z, d;
    logic [4:0] tg;
    int wc;
    bit seen;
    logic sg;
    for (int i = 0; i < 6; i++) begin
      do_div(fp_op[i], fp_a[i], fp_b[i], fp_tag[i], 32'h0BAD_0BAD, 32'h0BAD_0BAD, data, tg, wc, seen, z, d, sg);
      n_vec++; if (data !== fp_exp[i]) begin n_err++; $display("FAIL fast[%0d] wb_data got %h exp %h", i, data, fp_exp[i]); end
      n_vec++; if (tg !== fp_tag[i]) begin n_err++; $display("FAIL fast[%0d] wb_tag got %0d exp %0d", i, tg, fp_tag[i]); end
      n_vec++; if (wc !== 1) begin n_err++; $display("FAIL fast[%0d] wb cycle got %0d exp 1", i, wc); end
      n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL fast[%0d] div_valid seen got %b exp 0", i, seen); end
    end
  endtask

  task automatic test_flush_wait;
    bit wb_seen = 1'b0;
    send_req(2'd0, 32'd20, 32'd3, 5'd9);
    bus.div_ready = 1'b1;
    tick();
    bus.div_ready = 1'b0;
    n_vec++; if (bus.res_ready !== 1'b1) begin n_err++; $display("FAIL flush_wait res_ready in wait got %b exp 1", bus.res_ready); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_vec++; if ({busy, bus.req_ready, bus.res_ready} !== 3'b101) begin n_err++; $display("FAIL flush_wait drain busy/req_ready/res_ready got %b exp 101", {busy, bus.req_ready, bus.res_ready}); end
    for (int i = 0; i < 3; i++) begin
      wb_seen |= bus.wb_valid;
      tick();
    end
    n_vec++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL flush_wait req_ready before drain done got %b exp 0", bus.req_ready); end
    bus.res_valid = 1'b1;
    bus.res_q = 32'd6;
    bus.res_s = 32'd2;
    #1;
    wb_seen |= bus.wb_valid;
    tick();
    bus.res_valid = 1'b0;
    wb_seen |= bus.wb_valid;
    n_vec++; if (wb_seen !== 1'b0) begin n_err++; $display("FAIL flush_wait wb_valid seen got %b exp 0", wb_seen); end
    n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL flush_wait req_ready after drain got %b exp 1", bus.req_ready); end
    send_req(2'd1, 32'd20, 32'd3, 5'd10);
    bus.div_ready = 1'b1;
    tick();
    bus.div_ready = 1'b0;
    flush = 1'b1;
    bus.res_valid = 1'b1;
    #1;
    n_vec++; if ({bus.res_ready, bus.wb_valid} !== 2'b10) begin n_err++; $display("FAIL flush_res res_ready/wb_valid got %b exp 10", {bus.res_ready, bus.wb_valid}); end
    tick();
    flush = 1'b0;
    bus.res_valid = 1'b0;
    n_vec++; if ({bus.req_ready, bus.wb_valid, busy} !== 3'b100) begin n_err++; $display("FAIL flush_res req_ready/wb_valid/busy got %b exp 100", {bus.req_ready, bus.wb_valid, busy}); end
  endtask

  task automatic test_flush_issue;
    send_req(2'd0, 32'd50, 32'd7, 5'd11);
    n_vec++; if (bus.div_valid !== 1'b1) begin n_err++; $display("FAIL flush_issue div_valid in issue got %b exp 1", bus.div_valid); end
    bus.div_ready = 1'b1;
    flush = 1'b1;
    #1;
    n_vec++; if (bus.div_valid !== 1'b0) begin n_err++; $display("FAIL flush_issue div_valid under flush got %b exp 0", bus.div_valid); end
    tick();
    bus.div_ready = 1'b0;
    flush = 1'b0;
    n_vec++; if ({bus.req_ready, busy, bus.res_ready} !== 3'b100) begin n_err++; $display("FAIL flush_issue req_ready/busy/res_ready got %b exp 100", {bus.req_ready, busy, bus.res_ready}); end
    bus.req_valid = 1'b1;
    bus.req_b = 32'd3;
    flush = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    flush = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_idle busy got %b exp 0", busy); end
  endtask

  task automatic test_wb_stall;
    send_req(2'd1, 32'h1234, 32'h0, 5'd21);
    for (int i = 0; i < 10; i++) begin
      n_vec++; if ({bus.wb_valid, bus.req_ready, bus.wb_data, bus.wb_tag} !== {1'b1, 1'b0, 32'h1234, 5'd21})
        begin n_err++; $display("FAIL stall[%0d] wb_valid/req_ready/data/tag got %b/%b/%h/%0d exp 1/0/1234/21", i, bus.wb_valid, bus.req_ready, bus.wb_data, bus.wb_tag); end
      tick();
    end
    flush = 1'b1;
    bus.wb_ready = 1'b1;
    #1;
    n_vec++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL stall_flush wb_valid got %b exp 0", bus.wb_valid); end
    tick();
    flush = 1'b0;
    bus.wb_ready = 1'b0;
    n_vec++; if ({bus.req_ready, bus.wb_valid} !== 2'b10) begin n_err++; $display("FAIL stall_flush req_ready/wb_valid got %b exp 10", {bus.req_ready, bus.wb_valid}); end
  endtask

  task automatic test_reset_mid;
    send_req(2'd2, 32'd100, 32'd3, 5'd30);
    bus.div_ready = 1'b1;
    tick();
    bus.div_ready = 1'b0;
    n_vec++; if (bus.res_ready !== 1'b1) begin n_err++; $display("FAIL reset_mid res_ready in wait got %b exp 1", bus.res_ready); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_vec++; if ({busy, bus.req_ready, bus.res_ready} !== 3'b010) begin n_err++; $display("FAIL reset_mid busy/req_ready/res_ready got %b exp 010", {busy, bus.req_ready, bus.res_ready}); end
    n_vec++; if ({bus.div_z, bus.div_d, bus.wb_data} !== 96'h0) begin n_err++; $display("FAIL reset_mid div_z/div_d/wb_data got %h/%h/%h exp 0", bus.div_z, bus.div_d, bus.wb_data); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_divide();
    test_fast_path();
    test_flush_wait();
    test_flush_issue();
    test_wb_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
